// File: rtl/wb_commit_unit_if.sv
// Writeback/commit stage bus: MEM-stage instruction, dmem response, register-file write port,
// and commit reporting.
interface wb_commit_unit_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ORDER_W = 64
);
  localparam int unsigned AW = $clog2(XLEN / 8);

  logic                in_valid;
  logic                in_ready;
  logic                in_regf_we;
  logic [4:0]          in_rd_s;
  logic [1:0]          in_sel;
  logic [1:0]          in_ld_size;
  logic                in_ld_uns;
  logic [AW-1:0]       in_addr_lo;
  logic [XLEN-1:0]     in_u_imm;
  logic [XLEN-1:0]     in_alu_out;
  logic                in_br_en;
  logic                dmem_resp;
  logic [XLEN-1:0]     dmem_rdata;
  logic                regf_we;
  logic [4:0]          rd_sel;
  logic [XLEN-1:0]     rd_v;
  logic                commit_valid;
  logic [ORDER_W-1:0]  commit_order;
  logic                resp_ovf;

  // Pipeline / memory side drives the instruction and the load responses
  modport master (
    output in_valid, in_regf_we, in_rd_s, in_sel, in_ld_size, in_ld_uns, in_addr_lo,
           in_u_imm, in_alu_out, in_br_en, dmem_resp, dmem_rdata,
    input  in_ready, regf_we, rd_sel, rd_v, commit_valid, commit_order, resp_ovf
  );

  // Commit unit side
  modport slave (
    input  in_valid, in_regf_we, in_rd_s, in_sel, in_ld_size, in_ld_uns, in_addr_lo,
           in_u_imm, in_alu_out, in_br_en, dmem_resp, dmem_rdata,
    output in_ready, regf_we, rd_sel, rd_v, commit_valid, commit_order, resp_ovf
  );
endinterface

// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: one-entry instruction slot, rd value select with load alignment and
// extension, a small FIFO for early load responses, and a monotonic commit-order counter.
module wb_commit_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RESP_DEPTH = 2,
  parameter int unsigned ORDER_W    = 64
) (
  input logic             clk,
  input logic             rst,
  wb_commit_unit_if.slave bus
);
  localparam int unsigned AW = $clog2(XLEN / 8);
  localparam int unsigned PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RESP_DEPTH + 1);

  localparam logic [1:0] SelUimm = 2'd0;
  localparam logic [1:0] SelAlu  = 2'd1;
  localparam logic [1:0] SelBr   = 2'd2;
  localparam logic [1:0] SelLoad = 2'd3;

  typedef enum logic [1:0] {StEmpty, StReady, StWaitLd} slot_state_e;

  slot_state_e       r_state, w_state_d;
  logic              r_regf_we;
  logic [4:0]        r_rd_s;
  logic [1:0]        r_sel;
  logic [1:0]        r_ld_size;
  logic              r_ld_uns;
  logic [AW-1:0]     r_addr_lo;
  logic [XLEN-1:0]   r_u_imm;
  logic [XLEN-1:0]   r_alu_out;
  logic              r_br_en;

  logic [XLEN-1:0]   r_fifo [RESP_DEPTH];
  logic [PW-1:0]     r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]     r_count, w_count_d;
  logic [ORDER_W-1:0] r_order;
  logic              r_ovf;

  logic w_slot_valid, w_is_load, w_fifo_ne, w_fifo_full, w_data_avail;
  logic w_commit, w_ready, w_accept, w_ld_commit, w_pop, w_use_live, w_push_req, w_push, w_drop;

  logic [XLEN-1:0] w_ld_word, w_lane, w_ld_val, w_rd_v;
  logic [1:0]      w_eff_size;
  logic [AW-1:0]   w_off;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_slot_valid = (r_state != StEmpty);
  assign w_is_load    = (r_sel == SelLoad);
  assign w_fifo_ne    = (r_count != '0);
  assign w_fifo_full  = (r_count == CW'(RESP_DEPTH));
  assign w_data_avail = w_fifo_ne | bus.dmem_resp;
  assign w_commit     = w_slot_valid & (~w_is_load | w_data_avail);
  assign w_ready      = ~w_slot_valid | w_commit;
  assign w_accept     = bus.in_valid & w_ready;

  // The FIFO head always has priority over a live response so response order is preserved
  assign w_ld_commit  = w_commit & w_is_load;
  assign w_pop        = w_ld_commit & w_fifo_ne;
  assign w_use_live   = w_ld_commit & ~w_fifo_ne;
  assign w_push_req   = bus.dmem_resp & ~w_use_live;
  assign w_push       = w_push_req & (~w_fifo_full | w_pop);
  assign w_drop       = w_push_req & w_fifo_full & ~w_pop;
  assign w_count_d    = r_count + CW'(w_push) - CW'(w_pop);

  // Slot next state: a load enters StReady only if its data will already be buffered
  always_comb begin
    w_state_d = r_state;
    if (w_accept) begin
      if (bus.in_sel != SelLoad)  w_state_d = StReady;
      else if (w_count_d != '0)   w_state_d = StReady;
      else                        w_state_d = StWaitLd;
    end else if (w_commit) begin
      w_state_d = StEmpty;
    end
  end

  // Slot state and captured instruction fields
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StEmpty;
      r_regf_we  <= 1'b0;
      r_rd_s     <= '0;
      r_sel      <= SelUimm;
      r_ld_size  <= '0;
      r_ld_uns   <= 1'b0;
      r_addr_lo  <= '0;
      r_u_imm    <= '0;
      r_alu_out  <= '0;
      r_br_en    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_regf_we  <= bus.in_regf_we;
        r_rd_s     <= bus.in_rd_s;
        r_sel      <= bus.in_sel;
        r_ld_size  <= bus.in_ld_size;
        r_ld_uns   <= bus.in_ld_uns;
        r_addr_lo  <= bus.in_addr_lo;
        r_u_imm    <= bus.in_u_imm;
        r_alu_out  <= bus.in_alu_out;
        r_br_en    <= bus.in_br_en;
      end
    end
  end

  // Load-response FIFO and sticky overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(RESP_DEPTH); i++) r_fifo[i] <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= bus.dmem_rdata;
        r_wr_ptr         <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= w_count_d;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  // Commit-order counter, wraps naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_order <= '0;
    else if (w_commit) r_order <= r_order + ORDER_W'(1);
  end

  // Load lane select and extension; doubleword on a 32-bit datapath degrades to word
  always_comb begin
    w_ld_word  = w_fifo_ne ? r_fifo[r_rd_ptr] : bus.dmem_rdata;
    w_eff_size = (r_ld_size == 2'd3 && XLEN == 32) ? 2'd2 : r_ld_size;
    case (w_eff_size)
      2'd0:    w_off = r_addr_lo;
      2'd1:    w_off = r_addr_lo & ~AW'(1);
      2'd2:    w_off = r_addr_lo & ~AW'(3);
      default: w_off = '0;
    endcase
    w_lane = w_ld_word >> {w_off, 3'b000};
    case (w_eff_size)
      2'd0:    w_ld_val = r_ld_uns ? XLEN'(w_lane[7:0])  : XLEN'($signed(w_lane[7:0]));
      2'd1:    w_ld_val = r_ld_uns ? XLEN'(w_lane[15:0]) : XLEN'($signed(w_lane[15:0]));
      2'd2:    w_ld_val = r_ld_uns ? XLEN'(w_lane[31:0]) : XLEN'($signed(w_lane[31:0]));
      default: w_ld_val = w_lane;
    endcase
  end

  // rd value select
  always_comb begin
    case (r_sel)
      SelUimm: w_rd_v = r_u_imm;
      SelAlu:  w_rd_v = r_alu_out;
      SelBr:   w_rd_v = XLEN'(r_br_en);
      default: w_rd_v = w_ld_val;
    endcase
  end

  assign bus.in_ready     = w_ready;
  assign bus.commit_valid = w_commit;
  assign bus.regf_we      = w_commit & r_regf_we & (r_rd_s != 5'd0);
  assign bus.rd_sel       = w_commit ? r_rd_s : 5'd0;
  assign bus.rd_v         = w_commit ? w_rd_v : '0;
  assign bus.commit_order = r_order;
  assign bus.resp_ovf     = r_ovf;

  a_no_ld_d_on_rv32: assert property (@(posedge clk) disable iff (!rst)
    !(XLEN == 32 && w_accept && bus.in_sel == SelLoad && bus.in_ld_size == 2'd3));

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed self-checking bench for wb_commit_unit: 32-bit and 64-bit instances.
module tb_wb_commit_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  wb_commit_unit_if #(.XLEN(32), .ORDER_W(64)) bus32 ();
  wb_commit_unit_if #(.XLEN(64), .ORDER_W(64)) bus64 ();

  wb_commit_unit #(.XLEN(32), .RESP_DEPTH(2), .ORDER_W(64)) u_dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  wb_commit_unit #(.XLEN(64), .RESP_DEPTH(2), .ORDER_W(64)) u_dut64 (
    .clk (clk),
    .rst (rst),
    .bus (bus64)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    {bus32.in_valid, bus32.in_regf_we, bus32.in_rd_s, bus32.in_sel, bus32.in_ld_size,
     bus32.in_ld_uns, bus32.in_addr_lo, bus32.in_u_imm, bus32.in_alu_out, bus32.in_br_en,
     bus32.dmem_resp, bus32.dmem_rdata} = '0;
    {bus64.in_valid, bus64.in_regf_we, bus64.in_rd_s, bus64.in_sel, bus64.in_ld_size,
     bus64.in_ld_uns, bus64.in_addr_lo, bus64.in_u_imm, bus64.in_alu_out, bus64.in_br_en,
     bus64.dmem_resp, bus64.dmem_rdata} = '0;
    #2;
    chk("rst in_ready",     bus32.in_ready,     1);
    chk("rst commit_valid", bus32.commit_valid, 0);
    chk("rst regf_we",      bus32.regf_we,      0);
    chk("rst rd_sel",       bus32.rd_sel,       0);
    chk("rst rd_v",         bus32.rd_v,         0);
    chk("rst commit_order", bus32.commit_order, 0);
    chk("rst resp_ovf",     bus32.resp_ovf,     0);
    #10 rst = 1'b1;
    tick();

    // ALU op to x5
    bus32.in_valid = 1; bus32.in_regf_we = 1; bus32.in_rd_s = 5; bus32.in_sel = 2'd1;
    bus32.in_alu_out = 32'h1234;
    #1;
    chk("alu in_ready pre", bus32.in_ready, 1);
    chk("alu no commit pre", bus32.commit_valid, 0);
    tick();
    bus32.in_valid = 0;
    #1;
    chk("alu commit", bus32.commit_valid, 1);
    chk("alu regf_we", bus32.regf_we, 1);
    chk("alu rd_sel", bus32.rd_sel, 5);
    chk("alu rd_v", bus32.rd_v, 32'h1234);
    chk("alu order", bus32.commit_order, 0);
    tick();
    chk("alu slot empty", bus32.commit_valid, 0);
    chk("alu order inc", bus32.commit_order, 1);

    // lb at byte 3, response three cycles late
    bus32.in_valid = 1; bus32.in_rd_s = 6; bus32.in_sel = 2'd3; bus32.in_ld_size = 2'd0;
    bus32.in_ld_uns = 0; bus32.in_addr_lo = 2'd3;
    tick();
    bus32.in_valid = 0;
    #1;
    chk("lb wait1 in_ready", bus32.in_ready, 0);
    tick();
    chk("lb wait2 in_ready", bus32.in_ready, 0);
    tick();
    chk("lb wait3 in_ready", bus32.in_ready, 0);
    chk("lb wait3 no commit", bus32.commit_valid, 0);
    tick();
    bus32.dmem_resp = 1; bus32.dmem_rdata = 32'h80FF_0000;
    #1;
    chk("lb commit", bus32.commit_valid, 1);
    chk("lb in_ready", bus32.in_ready, 1);
    chk("lb rd_v", bus32.rd_v, 32'hFFFF_FF80);
    chk("lb rd_sel", bus32.rd_sel, 6);
    chk("lb order", bus32.commit_order, 1);
    tick();
    bus32.dmem_resp = 0;
    #1;
    chk("lb order inc", bus32.commit_order, 2);

    // Two early responses, then two back-to-back lhu loads
    bus32.dmem_resp = 1; bus32.dmem_rdata = 32'h0000_AAAA;
    tick();
    bus32.dmem_rdata = 32'h0000_BBBB;
    tick();
    bus32.dmem_resp = 0; bus32.dmem_rdata = 32'h0;
    bus32.in_valid = 1; bus32.in_rd_s = 7; bus32.in_sel = 2'd3; bus32.in_ld_size = 2'd1;
    bus32.in_ld_uns = 1; bus32.in_addr_lo = 2'd0;
    #1;
    chk("fifo2 no ovf", bus32.resp_ovf, 0);
    chk("fifo2 in_ready", bus32.in_ready, 1);
    tick();
    bus32.in_rd_s = 8;
    #1;
    chk("lhu1 commit", bus32.commit_valid, 1);
    chk("lhu1 rd_v", bus32.rd_v, 32'h0000_AAAA);
    chk("lhu1 rd_sel", bus32.rd_sel, 7);
    chk("lhu1 in_ready", bus32.in_ready, 1);
    tick();
    bus32.in_valid = 0;
    #1;
    chk("lhu2 commit", bus32.commit_valid, 1);
    chk("lhu2 rd_v", bus32.rd_v, 32'h0000_BBBB);
    chk("lhu2 rd_sel", bus32.rd_sel, 8);
    chk("lhu2 order", bus32.commit_order, 3);
    tick();
    chk("lhu done", bus32.commit_valid, 0);

    // Write to x0 still retires
    bus32.in_valid = 1; bus32.in_rd_s = 0; bus32.in_sel = 2'd1; bus32.in_alu_out = 32'd7;
    tick();
    bus32.in_sel = 2'd0; bus32.in_rd_s = 3; bus32.in_u_imm = 32'hABCD_E000;
    #1;
    chk("x0 commit", bus32.commit_valid, 1);
    chk("x0 regf_we", bus32.regf_we, 0);
    chk("x0 rd_v", bus32.rd_v, 32'd7);
    chk("x0 order", bus32.commit_order, 4);
    tick();
    bus32.in_sel = 2'd2; bus32.in_rd_s = 4; bus32.in_br_en = 1;
    #1;
    chk("uimm rd_v", bus32.rd_v, 32'hABCD_E000);
    chk("uimm regf_we", bus32.regf_we, 1);
    chk("uimm order", bus32.commit_order, 5);
    tick();
    bus32.in_valid = 0;
    #1;
    chk("br rd_v", bus32.rd_v, 32'd1);
    chk("br rd_sel", bus32.rd_sel, 4);
    tick();
    chk("br order inc", bus32.commit_order, 7);

    // Three unconsumed responses overflow a two-entry FIFO
    bus32.dmem_resp = 1; bus32.dmem_rdata = 32'd1;
    tick();
    bus32.dmem_rdata = 32'd2;
    tick();
    chk("ovf after 2", bus32.resp_ovf, 0);
    bus32.dmem_rdata = 32'd3;
    tick();
    bus32.dmem_resp = 0;
    #1;
    chk("ovf after 3", bus32.resp_ovf, 1);
    tick();
    chk("ovf sticky", bus32.resp_ovf, 1);
    #2 rst = 1'b0;
    #1;
    chk("ovf reset", bus32.resp_ovf, 0);
    chk("ovf reset order", bus32.commit_order, 0);
    #3 rst = 1'b1;
    tick();
    // Load after reset must wait: FIFO contents were discarded
    bus32.in_valid = 1; bus32.in_rd_s = 10; bus32.in_sel = 2'd3; bus32.in_ld_size = 2'd2;
    bus32.in_ld_uns = 0; bus32.in_addr_lo = 2'd0;
    tick();
    bus32.in_valid = 0;
    #1;
    chk("post-rst lw waits", bus32.in_ready, 0);
    chk("post-rst lw no commit", bus32.commit_valid, 0);
    bus32.dmem_resp = 1; bus32.dmem_rdata = 32'h7654_3210;
    #1;
    chk("post-rst lw rd_v", bus32.rd_v, 32'h7654_3210);
    chk("post-rst lw order", bus32.commit_order, 0);
    tick();
    bus32.dmem_resp = 0;

    // 64-bit datapath loads
    bus64.in_valid = 1; bus64.in_regf_we = 1; bus64.in_rd_s = 9; bus64.in_sel = 2'd3;
    bus64.in_ld_size = 2'd2; bus64.in_ld_uns = 1; bus64.in_addr_lo = 3'd4;
    tick();
    bus64.in_valid = 0;
    #1;
    chk("lwu64 waits", bus64.in_ready, 0);
    bus64.dmem_resp = 1; bus64.dmem_rdata = 64'h8000_0001_1234_5678;
    #1;
    chk("lwu64 commit", bus64.commit_valid, 1);
    chk("lwu64 rd_v", bus64.rd_v, 64'h0000_0000_8000_0001);
    chk("lwu64 rd_sel", bus64.rd_sel, 9);
    tick();
    bus64.dmem_resp = 0;
    bus64.in_valid = 1; bus64.in_ld_uns = 0;
    tick();
    bus64.in_valid = 0;
    bus64.dmem_resp = 1;
    #1;
    chk("lw64 rd_v", bus64.rd_v, 64'hFFFF_FFFF_8000_0001);
    tick();
    bus64.dmem_resp = 0;
    bus64.in_valid = 1; bus64.in_ld_size = 2'd0; bus64.in_addr_lo = 3'd7;
    tick();
    bus64.in_valid = 0;
    bus64.dmem_resp = 1;
    #1;
    chk("lb64 rd_v", bus64.rd_v, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb64 order", bus64.commit_order, 2);
    tick();
    bus64.dmem_resp = 0;

    // Reset while a load is waiting
    bus64.in_valid = 1; bus64.in_rd_s = 11; bus64.in_ld_uns = 1; bus64.in_addr_lo = 3'd0;
    tick();
    bus64.in_valid = 0;
    #1;
    chk("rst-wait in_ready pre", bus64.in_ready, 0);
    #2 rst = 1'b0;
    #1;
    chk("rst-wait in_ready", bus64.in_ready, 1);
    chk("rst-wait commit", bus64.commit_valid, 0);
    chk("rst-wait rd_v", bus64.rd_v, 0);
    chk("rst-wait regf_we", bus64.regf_we, 0);
    chk("rst-wait order", bus64.commit_order, 0);
    #2 rst = 1'b1;
    tick();
    chk("rst-wait slot stays empty", bus64.in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
